// File: rtl/uart_parity_pkg.sv
// Shared definitions for the UART parity engine: parity mode encoding,
// FSM state encoding and the legal data-length range.
package uart_parity_pkg;

   typedef enum logic [2:0] {
      MODE_NONE  = 3'd0,
      MODE_EVEN  = 3'd1,
      MODE_ODD   = 3'd2,
      MODE_MARK  = 3'd3,
      MODE_SPACE = 3'd4
   } parity_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_READY = 2'd2
   } parity_state_e;

   localparam int         DATA_W_MIN = 5;
   localparam int         DATA_W_MAX = 9;
   localparam logic [3:0] LEN_MIN    = 4'd5;

   // Modes 5..7 are reserved and treated as a configuration error.
   function automatic logic mode_legal(input logic [2:0] mode);
      return (mode <= 3'd4);
   endfunction

endpackage

// File: rtl/uart_parity_checker.sv
// Received-parity compare: registers a one-cycle error pulse when the
// sampled parity bit disagrees with the locally computed one.
module uart_parity_checker
   import uart_parity_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic chk_en_i,
   input  logic parity_bit_i,
   input  logic parity_exp_i,
   output logic parity_err_o
);

   // Error pulse lasts exactly one cycle after the qualified sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_err_o <= 1'b0;
      end else begin
         parity_err_o <= chk_en_i && (parity_bit_i != parity_exp_i);
      end
   end

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity engine: accumulates data-bit parity over one frame and
// presents the parity bit for the parity slot.
// Optional received-parity checking is built when UART_PARITY_CHECK_EN
// is defined; otherwise parity_err_o is tied low.
module uart_parity_engine
   import uart_parity_pkg::*;
#(
   parameter int DATA_W = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start_i,
   input  logic       bit_valid_i,
   input  logic       bit_i,
   input  logic [3:0] data_len_i,
   input  logic [2:0] mode_i,
   input  logic       parity_bit_valid_i,
   input  logic       parity_bit_i,
   output logic       parity_o,
   output logic       parity_ready_o,
   output logic       parity_err_o,
   output logic       busy_o,
   output logic       cfg_err_o
);

   localparam logic [3:0] LEN_MAX = 4'(DATA_W);

   parity_state_e state_q, state_d;
   logic [3:0]    len_q;
   logic [3:0]    count_q;
   logic [2:0]    mode_q;
   logic          acc_q;
   logic          cfg_err_q;
   logic          cfg_ok;
   logic          last_bit;

   assign cfg_ok   = (data_len_i >= LEN_MIN) && (data_len_i <= LEN_MAX) && mode_legal(mode_i);
   assign last_bit = ((count_q + 4'd1) == len_q);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a frame start overrides everything; an illegal config parks in IDLE.
   always_comb begin
      state_d = state_q;
      if (frame_start_i) begin
         state_d = cfg_ok ? ST_ACCUM : ST_IDLE;
      end else begin
         case (state_q)
            ST_ACCUM: if (bit_valid_i && last_bit) state_d = ST_READY;
            ST_READY: if (parity_bit_valid_i)      state_d = ST_IDLE;
            default:  state_d = state_q;
         endcase
      end
   end

   // Frame configuration, parity accumulator and bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q     <= 4'd0;
         mode_q    <= 3'd0;
         acc_q     <= 1'b0;
         count_q   <= 4'd0;
         cfg_err_q <= 1'b0;
      end else if (frame_start_i) begin
         len_q     <= data_len_i;
         mode_q    <= mode_i;
         cfg_err_q <= !cfg_ok;
         acc_q     <= cfg_ok && bit_valid_i && bit_i;
         count_q   <= (cfg_ok && bit_valid_i) ? 4'd1 : 4'd0;
      end else if ((state_q == ST_ACCUM) && bit_valid_i) begin
         acc_q     <= acc_q ^ bit_i;
         count_q   <= count_q + 4'd1;
      end
   end

   // Parity bit is only meaningful in READY; it idles high elsewhere.
   always_comb begin
      parity_o = 1'b1;
      if (state_q == ST_READY) begin
         case (mode_q)
            MODE_EVEN:  parity_o = acc_q;
            MODE_ODD:   parity_o = ~acc_q;
            MODE_MARK:  parity_o = 1'b1;
            MODE_SPACE: parity_o = 1'b0;
            default:    parity_o = 1'b1;
         endcase
      end
   end

   assign parity_ready_o = (state_q == ST_READY);
   assign busy_o         = (state_q != ST_IDLE);
   assign cfg_err_o      = cfg_err_q;

`ifdef UART_PARITY_CHECK_EN
   logic chk_en;
   assign chk_en = (state_q == ST_READY) && parity_bit_valid_i && (mode_q != MODE_NONE);

   uart_parity_checker u_checker (
      .clk          (clk),
      .rst          (rst),
      .chk_en_i     (chk_en),
      .parity_bit_i (parity_bit_i),
      .parity_exp_i (parity_o),
      .parity_err_o (parity_err_o)
   );
`else
   logic unused_parity_bit;
   assign unused_parity_bit = parity_bit_i;
   assign parity_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed testbench for uart_parity_engine (DATA_W = 9 so both the
// 9-bit frame and the length-range limits can be exercised).
module tb_uart_parity_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start_i = 1'b0;
   logic       bit_valid_i = 1'b0;
   logic       bit_i = 1'b0;
   logic [3:0] data_len_i = 4'd0;
   logic [2:0] mode_i = 3'd0;
   logic       parity_bit_valid_i = 1'b0;
   logic       parity_bit_i = 1'b0;
   logic       parity_o, parity_ready_o, parity_err_o, busy_o, cfg_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   uart_parity_engine #(.DATA_W(9)) dut (
      .clk                (clk),
      .rst                (rst),
      .frame_start_i      (frame_start_i),
      .bit_valid_i        (bit_valid_i),
      .bit_i              (bit_i),
      .data_len_i         (data_len_i),
      .mode_i             (mode_i),
      .parity_bit_valid_i (parity_bit_valid_i),
      .parity_bit_i       (parity_bit_i),
      .parity_o           (parity_o),
      .parity_ready_o     (parity_ready_o),
      .parity_err_o       (parity_err_o),
      .busy_o             (busy_o),
      .cfg_err_o          (cfg_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_frame(input logic [3:0] len, input logic [2:0] mode);
      @(negedge clk);
      frame_start_i = 1'b1; data_len_i = len; mode_i = mode;
      @(negedge clk);
      frame_start_i = 1'b0;
   endtask

   task automatic send_bits(input logic [8:0] d, input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         bit_valid_i = 1'b1; bit_i = d[i];
         @(negedge clk);
      end
      bit_valid_i = 1'b0; bit_i = 1'b0;
   endtask

   task automatic consume(input logic pbit);
      parity_bit_valid_i = 1'b1; parity_bit_i = pbit;
      @(negedge clk);
      parity_bit_valid_i = 1'b0; parity_bit_i = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #2;
      n_checks++; if (parity_o !== 1'b1) begin n_fail++; $display("FAIL reset parity_o got %b want 1", parity_o); end
      n_checks++; if (parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset parity_ready_o got %b want 0", parity_ready_o); end
      n_checks++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL reset parity_err_o got %b want 0", parity_err_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy_o got %b want 0", busy_o); end
      n_checks++; if (cfg_err_o !== 1'b0) begin n_fail++; $display("FAIL reset cfg_err_o got %b want 0", cfg_err_o); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // len 8, even, 0xA5 (four ones) -> parity 0
   task automatic test_even_a5();
      start_frame(4'd8, 3'd1);
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL even_a5 busy_o got %b want 1", busy_o); end
      send_bits(9'h0A5, 0, 7);
      n_checks++; if (parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL even_a5 early ready got %b want 0", parity_ready_o); end
      n_checks++; if (parity_o !== 1'b1) begin n_fail++; $display("FAIL even_a5 idle parity got %b want 1", parity_o); end
      send_bits(9'h0A5, 7, 8);
      n_checks++; if (parity_ready_o !== 1'b1) begin n_fail++; $display("FAIL even_a5 ready got %b want 1", parity_ready_o); end
      n_checks++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL even_a5 parity_o got %b want 0", parity_o); end
      send_bits(9'h001, 0, 1);
      n_checks++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL even_a5 bit in READY changed parity got %b want 0", parity_o); end
      consume(1'b0);
      n_checks++; if (parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL even_a5 ready after consume got %b want 0", parity_ready_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL even_a5 busy after consume got %b want 0", busy_o); end
   endtask

   // len 7 odd 0x07 -> 0; mark -> 1; space -> 0; none -> 1
   task automatic test_modes();
      start_frame(4'd7, 3'd2);
      send_bits(9'h007, 0, 3);
      consume(1'b1);
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL odd parity slot in ACCUM busy got %b want 1", busy_o); end
      send_bits(9'h007, 3, 7);
      n_checks++; if (parity_ready_o !== 1'b1) begin n_fail++; $display("FAIL odd ready got %b want 1", parity_ready_o); end
      n_checks++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL odd_07 parity_o got %b want 0", parity_o); end
      consume(1'b0);
      start_frame(4'd8, 3'd3);
      send_bits(9'h05A, 0, 8);
      n_checks++; if (parity_o !== 1'b1) begin n_fail++; $display("FAIL mark parity_o got %b want 1", parity_o); end
      consume(1'b1);
      start_frame(4'd5, 3'd4);
      send_bits(9'h01F, 0, 5);
      n_checks++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL space parity_o got %b want 0", parity_o); end
      consume(1'b0);
      start_frame(4'd6, 3'd0);
      send_bits(9'h001, 0, 6);
      n_checks++; if (parity_o !== 1'b1 || parity_ready_o !== 1'b1) begin n_fail++; $display("FAIL none parity_o/ready got %b/%b want 1/1", parity_o, parity_ready_o); end
      consume(1'b0);
      n_checks++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL none mode err got %b want 0", parity_err_o); end
   endtask

   // even 0x01 -> parity 1; received 0 is a mismatch
   task automatic test_check();
      logic exp_err;
`ifdef UART_PARITY_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      start_frame(4'd8, 3'd1);
      send_bits(9'h001, 0, 8);
      n_checks++; if (parity_o !== 1'b1) begin n_fail++; $display("FAIL check parity_o got %b want 1", parity_o); end
      consume(1'b0);
      n_checks++; if (parity_err_o !== exp_err) begin n_fail++; $display("FAIL check err pulse got %b want %b", parity_err_o, exp_err); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL check back to IDLE busy got %b want 0", busy_o); end
      @(negedge clk);
      n_checks++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL check err width got %b want 0", parity_err_o); end
      start_frame(4'd8, 3'd1);
      send_bits(9'h001, 0, 8);
      consume(1'b1);
      n_checks++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL check matched err got %b want 0", parity_err_o); end
   endtask

   // DATA_W=9, len 9, 0x1FF (nine ones), even -> 1
   task automatic test_len9();
      start_frame(4'd9, 3'd1);
      send_bits(9'h1FF, 0, 8);
      n_checks++; if (parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL len9 early ready got %b want 0", parity_ready_o); end
      send_bits(9'h1FF, 8, 9);
      n_checks++; if (parity_o !== 1'b1 || parity_ready_o !== 1'b1) begin n_fail++; $display("FAIL len9 parity/ready got %b/%b want 1/1", parity_o, parity_ready_o); end
      consume(1'b1);
   endtask

   task automatic test_cfg_err();
      start_frame(4'd4, 3'd1);
      n_checks++; if (cfg_err_o !== 1'b1) begin n_fail++; $display("FAIL cfg len4 cfg_err got %b want 1", cfg_err_o); end
      send_bits(9'h0FF, 0, 5);
      n_checks++; if (busy_o !== 1'b0 || parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL cfg len4 busy/ready got %b/%b want 0/0", busy_o, parity_ready_o); end
      n_checks++; if (cfg_err_o !== 1'b1) begin n_fail++; $display("FAIL cfg sticky got %b want 1", cfg_err_o); end
      start_frame(4'd8, 3'd6);
      n_checks++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL cfg mode6 cfg_err/busy got %b/%b want 1/0", cfg_err_o, busy_o); end
      start_frame(4'd10, 3'd1);
      n_checks++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL cfg len10 cfg_err/busy got %b/%b want 1/0", cfg_err_o, busy_o); end
      start_frame(4'd5, 3'd1);
      n_checks++; if (cfg_err_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL cfg cleared cfg_err/busy got %b/%b want 0/1", cfg_err_o, busy_o); end
      send_bits(9'h003, 0, 5);
      n_checks++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL cfg recovery parity got %b want 0", parity_o); end
      consume(1'b0);
   endtask

   task automatic test_reset_mid();
      start_frame(4'd8, 3'd1);
      send_bits(9'h007, 0, 3);
      #1 rst = 1'b0;
      #1;
      n_checks++; if (busy_o !== 1'b0 || parity_ready_o !== 1'b0 || parity_o !== 1'b1 || parity_err_o !== 1'b0 || cfg_err_o !== 1'b0)
         begin n_fail++; $display("FAIL reset_mid busy/ready/par/err/cfg got %b%b%b%b%b want 00100", busy_o, parity_ready_o, parity_o, parity_err_o, cfg_err_o); end
      @(negedge clk);
      rst = 1'b1;
      send_bits(9'h0FF, 0, 8);
      n_checks++; if (busy_o !== 1'b0 || parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid bits w/o start busy/ready got %b/%b want 0/0", busy_o, parity_ready_o); end
      start_frame(4'd8, 3'd1);
      send_bits(9'h007, 0, 3);
      start_frame(4'd5, 3'd1);
      send_bits(9'h001, 0, 4);
      n_checks++; if (parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL restart early ready got %b want 0", parity_ready_o); end
      send_bits(9'h001, 4, 5);
      n_checks++; if (parity_ready_o !== 1'b1 || parity_o !== 1'b1) begin n_fail++; $display("FAIL restart ready/parity got %b/%b want 1/1", parity_ready_o, parity_o); end
      consume(1'b1);
   endtask

   // frame start and first bit together count as bit 1
   task automatic test_same_cycle();
      @(negedge clk);
      frame_start_i = 1'b1; data_len_i = 4'd5; mode_i = 3'd1; bit_valid_i = 1'b1; bit_i = 1'b1;
      @(negedge clk);
      frame_start_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0;
      send_bits(9'h000, 0, 3);
      n_checks++; if (parity_ready_o !== 1'b0) begin n_fail++; $display("FAIL same_cycle early ready got %b want 0", parity_ready_o); end
      send_bits(9'h000, 0, 1);
      n_checks++; if (parity_ready_o !== 1'b1 || parity_o !== 1'b1) begin n_fail++; $display("FAIL same_cycle ready/parity got %b/%b want 1/1", parity_ready_o, parity_o); end
      consume(1'b1);
   endtask

   initial begin
      test_reset();
      test_even_a5();
      test_modes();
      test_check();
      test_len9();
      test_cfg_err();
      test_reset_mid();
      test_same_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
